// File: rtl/pam4_sym_src_if.sv
// Symbol-stream bundle between the PAM4 source, its strobe/control side and
// the SRRC transmit filter.
//
// Handshake: the source side asserts sym_clk_en for one sys_clk per symbol.
// The symbol side answers with sym_valid, a single-cycle pulse on the cycle
// after each strobe, and at that moment sym_out, sym_bits and frame_start are
// valid. There is no ready/backpressure: a consumer must take every pulse.
// sym_out holds its value between pulses.
interface pam4_sym_src_if;
    logic                sym_clk_en;
    logic                enable;
    logic [1:0]          mode;
    logic signed [17:0]  sym_out;
    logic [1:0]          sym_bits;
    logic                sym_valid;
    logic                frame_start;

    // Symbol producer (the pam4_sym_src itself).
    modport master (
        input  sym_clk_en, enable, mode,
        output sym_out, sym_bits, sym_valid, frame_start
    );

    // Control driver and symbol consumer.
    modport slave (
        output sym_clk_en, enable, mode,
        input  sym_out, sym_bits, sym_valid, frame_start
    );
endinterface

// File: rtl/pam4_sym_src.sv
// PAM4 symbol source: PRBS-22 (Gray-mapped bit pairs), impulse train,
// constant and alternating patterns, one symbol per sym_clk_en strobe.
// Also exports the raw PRBS bit pair and a frame marker for alignment.
module pam4_sym_src #(
    parameter logic [21:0]        SEED       = 22'h000001,
    parameter logic signed [17:0] LVL_P3     = 18'sd98304,
    parameter logic signed [17:0] LVL_P1     = 18'sd32768,
    parameter int                 IMP_PERIOD = 32,
    parameter int                 FRAME_LEN  = 1024
) (
    input  logic          sys_clk,
    input  logic          reset,
    pam4_sym_src_if.master bus
);

    localparam logic [1:0]  MODE_PRBS  = 2'b00;
    localparam logic [1:0]  MODE_IMP   = 2'b01;
    localparam logic [1:0]  MODE_CONST = 2'b10;
    localparam logic [1:0]  MODE_ALT   = 2'b11;
    localparam logic [7:0]  IMP_LAST   = 8'(IMP_PERIOD - 1);
    localparam logic [15:0] FRAME_LAST = 16'(FRAME_LEN - 1);

    // Registered state
    logic [21:0]        lfsr;
    logic [7:0]         imp_cnt;
    logic               alt;
    logic [15:0]        frame_cnt;
    logic [1:0]         prev_mode;
    logic signed [17:0] sym_out_q;
    logic [1:0]         sym_bits_q;
    logic               sym_valid_q;
    logic               frame_start_q;

    // Next-state values, meaningful only on strobe cycles
    logic [21:0]        lfsr_nxt;
    logic [7:0]         imp_nxt;
    logic               alt_nxt;
    logic [15:0]        frame_nxt;
    logic signed [17:0] sym_nxt;
    logic [1:0]         bits_nxt;
    logic               fs_nxt;

    // Working signals
    logic               fb1;
    logic               fb2;
    logic               lock;
    logic               imp_entry;
    logic               alt_entry;
    logic [7:0]         imp_eff;
    logic               alt_eff;

    // Gray map: adjacent levels differ in one bit.
    function automatic logic signed [17:0] gray_level(input logic [1:0] b);
        case (b)
            2'b00:   return -LVL_P3;
            2'b01:   return -LVL_P1;
            2'b11:   return LVL_P1;
            default: return LVL_P3;
        endcase
    endfunction

    // Next-state and next-symbol computation for the coming strobe.
    always_comb begin
        // Two LFSR steps per symbol: fb2 is the feedback of the shifted state.
        fb1       = lfsr[21] ^ lfsr[20];
        fb2       = lfsr[20] ^ lfsr[19];
        lock      = (lfsr == 22'd0);
        // Pattern counters restart on entry even if this strobe is disabled.
        imp_entry = (bus.mode == MODE_IMP) && (prev_mode != MODE_IMP);
        alt_entry = (bus.mode == MODE_ALT) && (prev_mode != MODE_ALT);
        imp_eff   = imp_entry ? 8'd0 : imp_cnt;
        alt_eff   = alt_entry ? 1'b0 : alt;

        lfsr_nxt  = lock ? SEED : lfsr;
        imp_nxt   = imp_eff;
        alt_nxt   = alt_eff;
        frame_nxt = frame_cnt;
        sym_nxt   = '0;
        bits_nxt  = 2'b00;
        fs_nxt    = 1'b0;

        if (bus.enable) begin
            frame_nxt = (frame_cnt == FRAME_LAST) ? 16'd0 : frame_cnt + 16'd1;
            fs_nxt    = (frame_cnt == 16'd0);
            case (bus.mode)
                MODE_PRBS: begin
                    if (!lock) begin
                        lfsr_nxt = {lfsr[19:0], fb1, fb2};
                        bits_nxt = {fb1, fb2};
                        sym_nxt  = gray_level({fb1, fb2});
                    end
                end
                MODE_IMP: begin
                    sym_nxt = (imp_eff == 8'd0) ? LVL_P3 : '0;
                    imp_nxt = (imp_eff == IMP_LAST) ? 8'd0 : imp_eff + 8'd1;
                end
                MODE_CONST: begin
                    sym_nxt = LVL_P1;
                end
                default: begin
                    sym_nxt = alt_eff ? -LVL_P3 : LVL_P3;
                    alt_nxt = ~alt_eff;
                end
            endcase
            // A locked-up LFSR always yields a zero symbol that strobe.
            if (lock) begin
                sym_nxt  = '0;
                bits_nxt = 2'b00;
            end
        end
    end

    // State and output registers; everything except the valid pulse holds between strobes.
    always_ff @(posedge sys_clk or posedge reset) begin
        if (reset) begin
            lfsr          <= SEED;
            imp_cnt       <= 8'd0;
            alt           <= 1'b0;
            frame_cnt     <= 16'd0;
            prev_mode     <= MODE_PRBS;
            sym_out_q     <= '0;
            sym_bits_q    <= 2'b00;
            sym_valid_q   <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            sym_valid_q   <= bus.sym_clk_en;
            frame_start_q <= bus.sym_clk_en & fs_nxt;
            if (bus.sym_clk_en) begin
                lfsr       <= lfsr_nxt;
                imp_cnt    <= imp_nxt;
                alt        <= alt_nxt;
                frame_cnt  <= frame_nxt;
                prev_mode  <= bus.mode;
                sym_out_q  <= sym_nxt;
                sym_bits_q <= bits_nxt;
            end
        end
    end

    assign bus.sym_out     = sym_out_q;
    assign bus.sym_bits    = sym_bits_q;
    assign bus.sym_valid   = sym_valid_q;
    assign bus.frame_start = frame_start_q;

endmodule

// File: tb/tb_pam4_sym_src.sv
// Bench for pam4_sym_src: randomized strobes/modes checked against a
// symbol-level reference model.
module tb_pam4_sym_src;
    localparam logic [21:0] SEED       = 22'h000001;
    localparam int          P3         = 98304;
    localparam int          P1         = 32768;
    localparam int          IMP_PERIOD = 32;
    localparam int          FRAME_LEN  = 1024;

    logic sys_clk = 1'b0;
    logic reset   = 1'b1;
    int   checks  = 0;
    int   errors  = 0;

    pam4_sym_src_if bus();

    pam4_sym_src dut (
        .sys_clk (sys_clk),
        .reset   (reset),
        .bus     (bus)
    );

    // Clock
    always #10 sys_clk = ~sys_clk;

    // Reference model state: the LFSR as a bit generator, pattern phases as
    // plain symbol counts since entering the mode, and enabled-symbol count.
    logic [21:0] m_lfsr;
    logic [1:0]  m_prev;
    int          m_imp_n;
    int          m_alt_n;
    int          m_frames;

    task automatic model_reset();
        m_lfsr   = SEED;
        m_prev   = 2'b00;
        m_imp_n  = 0;
        m_alt_n  = 0;
        m_frames = 0;
    endtask

    task automatic prbs_bit(output logic b);
        b      = m_lfsr[21] ^ m_lfsr[20];
        m_lfsr = {m_lfsr[20:0], b};
    endtask

    task automatic model_step(input logic en, input logic [1:0] md,
                              output logic signed [31:0] e_sym,
                              output logic [1:0] e_bits, output logic e_fs);
        logic b1, b0, lock;
        e_sym  = 0;
        e_bits = 2'b00;
        e_fs   = 1'b0;
        if (md != m_prev) begin
            if (md == 2'b01) m_imp_n = 0;
            if (md == 2'b11) m_alt_n = 0;
        end
        m_prev = md;
        lock   = (m_lfsr == 22'd0);
        if (lock) m_lfsr = SEED;
        if (en) begin
            e_fs = ((m_frames % FRAME_LEN) == 0);
            m_frames++;
            case (md)
                2'b00: if (!lock) begin
                    prbs_bit(b1);
                    prbs_bit(b0);
                    e_bits = {b1, b0};
                    case ({b1, b0})
                        2'b00:   e_sym = -P3;
                        2'b01:   e_sym = -P1;
                        2'b11:   e_sym = P1;
                        default: e_sym = P3;
                    endcase
                end
                2'b01: begin
                    e_sym = ((m_imp_n % IMP_PERIOD) == 0) ? P3 : 0;
                    m_imp_n++;
                end
                2'b10: e_sym = P1;
                default: begin
                    e_sym = ((m_alt_n % 2) == 0) ? P3 : -P3;
                    m_alt_n++;
                end
            endcase
            if (lock) begin
                e_sym  = 0;
                e_bits = 2'b00;
            end
        end
    endtask

    // Driver: one strobe, outputs sampled 1 ns after the active edge.
    task automatic drive_strobe(input logic en, input logic [1:0] md,
                                output logic signed [31:0] o_sym,
                                output logic [1:0] o_bits,
                                output logic o_valid, output logic o_fs);
        @(negedge sys_clk);
        bus.sym_clk_en = 1'b1;
        bus.enable     = en;
        bus.mode       = md;
        @(posedge sys_clk);
        #1;
        o_sym   = 32'(bus.sym_out);
        o_bits  = bus.sym_bits;
        o_valid = bus.sym_valid;
        o_fs    = bus.frame_start;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge sys_clk);
            bus.sym_clk_en = 1'b0;
            @(posedge sys_clk);
            #1;
        end
    endtask

    task automatic test_reset();
        checks++;
        if (bus.sym_out !== 18'd0 || bus.sym_bits !== 2'b00 ||
            bus.sym_valid !== 1'b0 || bus.frame_start !== 1'b0) begin
            errors++;
            $display("FAIL reset_values: sym=%0d bits=%b valid=%b fs=%b, expected all zero",
                     bus.sym_out, bus.sym_bits, bus.sym_valid, bus.frame_start);
        end
        @(negedge sys_clk);
        reset = 1'b0;
        idle(2);
        checks++;
        if (bus.sym_valid !== 1'b0 || bus.sym_out !== 18'd0) begin
            errors++;
            $display("FAIL idle_after_reset: valid=%b sym=%0d, expected valid=0 sym=0",
                     bus.sym_valid, bus.sym_out);
        end
    endtask

    task automatic test_prbs_seed();
        logic signed [31:0] e_sym, o_sym, c_sym;
        logic [1:0] e_bits, o_bits, c_bits;
        logic e_fs, o_fs, o_valid;
        for (int i = 0; i < 12; i++) begin
            model_step(1'b1, 2'b00, e_sym, e_bits, e_fs);
            drive_strobe(1'b1, 2'b00, o_sym, o_bits, o_valid, o_fs);
            checks++;
            if (o_sym !== e_sym || o_bits !== e_bits || o_valid !== 1'b1 || o_fs !== e_fs) begin
                errors++;
                $display("FAIL prbs_seed_model[%0d]: sym=%0d bits=%b valid=%b fs=%b, expected %0d %b 1 %b",
                         i, o_sym, o_bits, o_valid, o_fs, e_sym, e_bits, e_fs);
            end
            if (i <= 10) begin
                c_sym  = (i < 10) ? -P3 : P1;
                c_bits = (i < 10) ? 2'b00 : 2'b11;
                checks++;
                if (o_sym !== c_sym || o_bits !== c_bits || o_fs !== (i == 0)) begin
                    errors++;
                    $display("FAIL prbs_seed_known[%0d]: sym=%0d bits=%b fs=%b, expected %0d %b %b",
                             i, o_sym, o_bits, o_fs, c_sym, c_bits, (i == 0));
                end
            end
        end
    endtask

    task automatic test_prbs_gaps();
        logic signed [31:0] e_sym, o_sym;
        logic [1:0] e_bits, o_bits;
        logic e_fs, o_fs, o_valid;
        int gap;
        for (int i = 0; i < 150; i++) begin
            model_step(1'b1, 2'b00, e_sym, e_bits, e_fs);
            drive_strobe(1'b1, 2'b00, o_sym, o_bits, o_valid, o_fs);
            checks++;
            if (o_sym !== e_sym || o_bits !== e_bits || o_valid !== 1'b1 || o_fs !== e_fs) begin
                errors++;
                $display("FAIL prbs_gaps[%0d]: sym=%0d bits=%b valid=%b fs=%b, expected %0d %b 1 %b",
                         i, o_sym, o_bits, o_valid, o_fs, e_sym, e_bits, e_fs);
            end
            gap = $urandom_range(0, 2);
            if (gap > 0) begin
                idle(gap);
                checks++;
                if (bus.sym_valid !== 1'b0 || 32'(bus.sym_out) !== e_sym || bus.frame_start !== 1'b0) begin
                    errors++;
                    $display("FAIL prbs_hold[%0d]: valid=%b sym=%0d fs=%b, expected valid=0 sym=%0d fs=0",
                             i, bus.sym_valid, bus.sym_out, bus.frame_start, e_sym);
                end
            end
        end
    endtask

    task automatic test_impulse();
        logic signed [31:0] e_sym, o_sym, c_sym;
        logic [1:0] e_bits, o_bits;
        logic e_fs, o_fs, o_valid;
        for (int i = 0; i < 75; i++) begin
            logic [1:0] md;
            md = (i < 5) ? 2'b00 : 2'b01;
            model_step(1'b1, md, e_sym, e_bits, e_fs);
            drive_strobe(1'b1, md, o_sym, o_bits, o_valid, o_fs);
            checks++;
            if (o_sym !== e_sym || o_bits !== e_bits || o_valid !== 1'b1 || o_fs !== e_fs) begin
                errors++;
                $display("FAIL impulse_model[%0d]: sym=%0d bits=%b valid=%b fs=%b, expected %0d %b 1 %b",
                         i, o_sym, o_bits, o_valid, o_fs, e_sym, e_bits, e_fs);
            end
            if (i >= 5) begin
                c_sym = (((i - 5) % 32) == 0) ? P3 : 0;
                checks++;
                if (o_sym !== c_sym || o_bits !== 2'b00) begin
                    errors++;
                    $display("FAIL impulse_known[%0d]: sym=%0d bits=%b, expected %0d 00",
                             i - 5, o_sym, o_bits, c_sym);
                end
            end
        end
    endtask

    task automatic test_alt_const();
        logic signed [31:0] e_sym, o_sym, c_sym;
        logic [1:0] e_bits, o_bits, md;
        logic e_fs, o_fs, o_valid;
        for (int i = 0; i < 30; i++) begin
            md = (i < 6) ? 2'b11 : (i < 10) ? 2'b10 : 2'b00;
            model_step(1'b1, md, e_sym, e_bits, e_fs);
            drive_strobe(1'b1, md, o_sym, o_bits, o_valid, o_fs);
            checks++;
            if (o_sym !== e_sym || o_bits !== e_bits || o_valid !== 1'b1 || o_fs !== e_fs) begin
                errors++;
                $display("FAIL alt_const_model[%0d]: sym=%0d bits=%b valid=%b fs=%b, expected %0d %b 1 %b",
                         i, o_sym, o_bits, o_valid, o_fs, e_sym, e_bits, e_fs);
            end
            if (i < 10) begin
                c_sym = (i >= 6) ? P1 : ((i % 2) == 0) ? P3 : -P3;
                checks++;
                if (o_sym !== c_sym) begin
                    errors++;
                    $display("FAIL alt_const_known[%0d]: sym=%0d, expected %0d", i, o_sym, c_sym);
                end
            end
        end
    endtask

    task automatic test_enable_hold();
        logic signed [31:0] e_sym, o_sym;
        logic [1:0] e_bits, o_bits;
        logic e_fs, o_fs, o_valid, en;
        for (int i = 0; i < 30; i++) begin
            en = !(i >= 5 && i < 10);
            model_step(en, 2'b00, e_sym, e_bits, e_fs);
            drive_strobe(en, 2'b00, o_sym, o_bits, o_valid, o_fs);
            checks++;
            if (o_sym !== e_sym || o_bits !== e_bits || o_valid !== 1'b1 || o_fs !== e_fs) begin
                errors++;
                $display("FAIL enable_hold[%0d]: sym=%0d bits=%b valid=%b fs=%b, expected %0d %b 1 %b",
                         i, o_sym, o_bits, o_valid, o_fs, e_sym, e_bits, e_fs);
            end
            if (!en) begin
                checks++;
                if (o_sym !== 0 || o_bits !== 2'b00 || o_valid !== 1'b1) begin
                    errors++;
                    $display("FAIL disabled_zero[%0d]: sym=%0d bits=%b valid=%b, expected 0 00 1",
                             i, o_sym, o_bits, o_valid);
                end
            end
        end
    endtask

    task automatic test_lockup();
        logic signed [31:0] e_sym, o_sym;
        logic [1:0] e_bits, o_bits;
        logic e_fs, o_fs, o_valid;
        idle(1);
        @(negedge sys_clk);
        force dut.lfsr = 22'd0;
        #1;
        release dut.lfsr;
        m_lfsr = 22'd0;
        for (int i = 0; i < 25; i++) begin
            model_step(1'b1, 2'b00, e_sym, e_bits, e_fs);
            drive_strobe(1'b1, 2'b00, o_sym, o_bits, o_valid, o_fs);
            checks++;
            if (o_sym !== e_sym || o_bits !== e_bits || o_valid !== 1'b1 || o_fs !== e_fs) begin
                errors++;
                $display("FAIL lockup[%0d]: sym=%0d bits=%b valid=%b fs=%b, expected %0d %b 1 %b",
                         i, o_sym, o_bits, o_valid, o_fs, e_sym, e_bits, e_fs);
            end
            // After the zero symbol the seed sequence restarts: ten outer-negative symbols.
            if (i <= 10) begin
                checks++;
                if (o_sym !== ((i == 0) ? 0 : -P3)) begin
                    errors++;
                    $display("FAIL lockup_known[%0d]: sym=%0d, expected %0d",
                             i, o_sym, (i == 0) ? 0 : -P3);
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        logic signed [31:0] e_sym, o_sym;
        logic [1:0] e_bits, o_bits;
        logic e_fs, o_fs, o_valid;
        for (int i = 0; i < 3; i++) begin
            model_step(1'b1, 2'b00, e_sym, e_bits, e_fs);
            drive_strobe(1'b1, 2'b00, o_sym, o_bits, o_valid, o_fs);
        end
        #3;
        bus.sym_clk_en = 1'b0;
        reset = 1'b1;
        #1;
        checks++;
        if (bus.sym_out !== 18'd0 || bus.sym_bits !== 2'b00 ||
            bus.sym_valid !== 1'b0 || bus.frame_start !== 1'b0) begin
            errors++;
            $display("FAIL reset_async: sym=%0d bits=%b valid=%b fs=%b, expected all zero",
                     bus.sym_out, bus.sym_bits, bus.sym_valid, bus.frame_start);
        end
        @(negedge sys_clk);
        reset = 1'b0;
        model_reset();
        for (int k = 0; k < FRAME_LEN + 2; k++) begin
            model_step(1'b1, 2'b00, e_sym, e_bits, e_fs);
            drive_strobe(1'b1, 2'b00, o_sym, o_bits, o_valid, o_fs);
            checks++;
            if (o_sym !== e_sym || o_bits !== e_bits || o_valid !== 1'b1 ||
                o_fs !== ((k % FRAME_LEN) == 0)) begin
                errors++;
                $display("FAIL frame_after_reset[%0d]: sym=%0d bits=%b valid=%b fs=%b, expected %0d %b 1 %b",
                         k, o_sym, o_bits, o_valid, o_fs, e_sym, e_bits, ((k % FRAME_LEN) == 0));
            end
        end
    endtask

    task automatic test_random_mix();
        logic signed [31:0] e_sym, o_sym;
        logic [1:0] e_bits, o_bits, md;
        logic e_fs, o_fs, o_valid, en;
        for (int i = 0; i < 400; i++) begin
            en = ($urandom_range(0, 9) != 0);
            md = 2'($urandom_range(0, 3));
            model_step(en, md, e_sym, e_bits, e_fs);
            drive_strobe(en, md, o_sym, o_bits, o_valid, o_fs);
            checks++;
            if (o_sym !== e_sym || o_bits !== e_bits || o_valid !== 1'b1 || o_fs !== e_fs) begin
                errors++;
                $display("FAIL random_mix[%0d] en=%b mode=%b: sym=%0d bits=%b valid=%b fs=%b, expected %0d %b 1 %b",
                         i, en, md, o_sym, o_bits, o_valid, o_fs, e_sym, e_bits, e_fs);
            end
            if ($urandom_range(0, 3) == 0) idle(1);
        end
    endtask

    initial begin
        bus.sym_clk_en = 1'b0;
        bus.enable     = 1'b0;
        bus.mode       = 2'b00;
        model_reset();
        repeat (3) @(posedge sys_clk);
        #1;
        test_reset();
        test_prbs_seed();
        test_prbs_gaps();
        test_impulse();
        test_alt_const();
        test_enable_hold();
        test_lockup();
        test_reset_mid();
        test_random_mix();
        idle(2);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/pam4_sym_src.md
# pam4_sym_src

Upstream stimulus/data source for the SRRC transmit filter. On each symbol strobe it produces one 18-bit signed 4-level PAM symbol (1s17), taken from a 22-bit PRBS, an impulse train, a constant or an alternating pattern. It also exports the raw bit pair and a frame marker so downstream BER and impulse-capture logic can align to the stream. Its output connects directly to the filter's symbol input in the sys_clk domain and is paced by clk_gen's enables.

## Interface
- SEED, 22'h000001: LFSR load value on reset and on lock-up recovery; must be non-zero.
- LVL_P3, 18'sd98304: outer level (+0.75 in 1s17); −LVL_P3 is its two's complement.
- LVL_P1, 18'sd32768: inner level (+0.25 in 1s17).
- IMP_PERIOD, 32: symbols per impulse-train period; 2..255.
- FRAME_LEN, 1024: symbols per frame marker period; 2..65535.
- sys_clk  in  1  system clock, 50 MHz.
- reset  in  1  asynchronous, active-high.
- sym_clk_en  in  1  one-sys_clk strobe per symbol, from clk_gen.
- enable  in  1  run/hold control, sampled on sym_clk_en cycles.
- mode  in  2  source select, sampled on sym_clk_en cycles: 00 PRBS, 01 impulse, 10 constant +LVL_P1, 11 alternating ±LVL_P3.
- sym_out  out  18  signed symbol to the TX filter; registered.
- sym_bits  out  2  bit pair behind sym_out in PRBS mode; 00 in other modes.
- sym_valid  out  1  one-cycle pulse, high on the cycle sym_out updates.
- frame_start  out  1  high together with sym_valid for symbol 0 of each frame.

## Operation
- All state updates only on sys_clk edges with sym_clk_en=1; otherwise every register holds.
- enable=0 on a strobe: sym_out←0, sym_bits←00, sym_valid←1, LFSR and counters hold. Filter input stays defined.
- LFSR: Fibonacci, polynomial x^22+x^21+1, feedback fb=s[21]^s[20], update s←{s[20:0],fb}.
  - PRBS mode: advances two steps per symbol. b1 is the first fb, b0 the second; sym_bits={b1,b0}.
  - Other modes: the LFSR holds.
- Lock-up guard: if s==0 at any strobe, reload SEED that cycle and output 0.
- Gray map: 00→−LVL_P3, 01→−LVL_P1, 11→+LVL_P1, 10→+LVL_P3.
- Impulse mode:
  - imp_cnt counts 0..IMP_PERIOD−1 and wraps.
  - sym_out=+LVL_P3 when imp_cnt==0, else 0.
  - imp_cnt clears to 0 on the strobe where mode changes to 01, so the first symbol after entry is the impulse.
- Alternating mode:
  - alt toggles every symbol; sym_out=+LVL_P3 when alt=0, −LVL_P3 when alt=1.
  - alt clears to 0 on entry.
- frame_cnt counts enabled strobes 0..FRAME_LEN−1 in every mode and wraps. frame_start=(frame_cnt==0)&sym_valid.
- Mode change takes effect on the strobe where it is sampled. There is no mid-symbol glitch because outputs only change on strobes.

## Timing
- Reset values: sym_out=0, sym_bits=00, sym_valid=0, frame_start=0, s=SEED, imp_cnt=0, alt=0, frame_cnt=0, prev_mode=00.
- Latency: the symbol is computed and registered on the strobe edge and visible one sys_clk later. sym_valid is high for exactly that one cycle.
- Back-to-back strobes (sym_clk_en held high) must produce one symbol per cycle with no skipped LFSR steps.
- Reset asserted mid-run: all outputs return to reset values immediately, without waiting for a clock. After deassertion, the first strobe yields symbol 0 of the seed sequence and frame_start=1.
- enable and mode change on the same strobe: enable wins (output 0), and the new mode's counters still clear.
- Arithmetic: levels are stored as signed 18-bit values. Negation is two's complement with no saturation, since the levels never equal −2^17.

## Test plan
- PRBS, SEED=1, enable=1, mode=00:
  - symbols 0–9 must be −98304 (0x28000) with sym_bits=00.
  - symbol 10 must be +32768 with sym_bits=11.
  - frame_start must be high on symbol 0 only.
- Impulse mode with IMP_PERIOD=32: sym_out=+98304 on symbols 0, 32, 64, and 0 on all others. Switching 00→01 mid-run must emit the impulse on the first 01 symbol.
- Alternating and constant modes: mode=11 gives +98304, −98304, … starting positive; mode=10 gives a steady +32768. The LFSR value must be unchanged on returning to 00.
- enable=0 for 5 strobes inside PRBS: five 0 outputs, each with sym_valid. After re-enable the sequence resumes exactly where it stopped.
- Force s=0 (bench force): the next strobe outputs 0 and reloads SEED, and the following symbols match the seed sequence.
- Reset asserted between strobes: outputs are 0 within the same sys_clk cycle. After deassertion the symbol 0 of the seed sequence repeats, and frame_cnt restarts so frame_start recurs every FRAME_LEN strobes.
